pps_duty_ctrl: RTL and testbench

- Disciplining loop stage directly upstream of the PWM tuning-voltage generator. Sole source of its 16-bit PWM_Duty.
- Measures the number of CLK_SYS (OCXO-derived) cycles between GPS 1PPS rising edges and computes a signed frequency error against the nominal count.
- Runs a saturating shift-based PI controller and updates the duty word once per valid second.
- Detects loss of PPS (holdover) and reports lock status.

---
 rtl/pps_duty_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pps_duty_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_duty_ctrl.sv
// GPS 1PPS disciplining stage: counts CLK_SYS cycles per PPS period, runs a
// shift-based PI loop on the frequency error and drives the PWM duty word.
module pps_duty_ctrl #(
    parameter int NOMINAL   = 10000000,
    parameter int GROSS_LIM = 1000,
    parameter int ERR_LIM   = 500,
    parameter int KP_SH     = 4,
    parameter int KI_SH     = 2,
    parameter int INT_LIM   = 65536,
    parameter int DUTY_INIT = 32768,
    parameter int DUTY_MIN  = 1024,
    parameter int DUTY_MAX  = 64511,
    parameter int TIMEOUT   = 15000000,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_CNT  = 8
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        PPS_In,
    output logic [15:0] PWM_Duty,
    output logic        Duty_Valid,
    output logic [15:0] Freq_Err,
    output logic        Locked,
    output logic        Holdover
);

    localparam int unsigned CW  = 32;
    localparam int unsigned DW  = 40;
    localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

    typedef enum logic [2:0] {
        ST_ACQ,
        ST_MEAS,
        ST_C1,
        ST_C2,
        ST_C3,
        ST_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [2:0]           pps_sync;
    logic                 pps_rise;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        meas;
    logic                 pend, pend_d;
    logic signed [15:0]   err_q, err_d;
    logic signed [DW-1:0] p_q, p_d;
    logic signed [DW-1:0] integ_q, integ_d;
    logic [LCW-1:0]       lcnt_q, lcnt_d;
    logic [15:0]          duty_d, ferr_d;
    logic                 dv_d, locked_d, hold_d;
    logic signed [DW-1:0] diff_c, isum_c, raw_c;
    logic                 gross_c, timeout_c, evt_c, in_tol_c;

    // Left unreset so a reset while PPS_In is high cannot fabricate an edge.
    always_ff @(posedge CLK_SYS) begin
        pps_sync <= {pps_sync[1:0], PPS_In};
    end

    assign pps_rise = pps_sync[1] & ~pps_sync[2];

    // Free-running period counter; meas holds cycles between the last two edges.
    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            cnt  <= '0;
            meas <= '0;
        end else if (pps_rise) begin
            meas <= (&cnt) ? cnt : cnt + CW'(1);
            cnt  <= '0;
        end else if (!(&cnt)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign timeout_c = (cnt == CW'(TIMEOUT - 1));
    assign evt_c     = pps_rise | pend;
    assign diff_c    = $signed({{(DW-CW){1'b0}}, meas}) - DW'(NOMINAL);
    assign gross_c   = (diff_c > DW'(GROSS_LIM)) || (diff_c < -DW'(GROSS_LIM));
    assign isum_c    = integ_q + (DW'(err_q) <<< KI_SH);
    assign raw_c     = DW'(DUTY_INIT) - (p_q + integ_q);
    assign in_tol_c  = (err_q <= 16'(LOCK_TOL)) && (err_q >= -16'(LOCK_TOL));

    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            state <= ST_ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    // An edge seen mid-calculation is replayed through C1 and lands as a gross discard.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACQ, ST_HOLD: begin
                if (pps_rise) state_nxt = ST_MEAS;
            end
            ST_MEAS: begin
                if (pps_rise)       state_nxt = ST_C1;
                else if (timeout_c) state_nxt = ST_HOLD;
            end
            ST_C1: begin
                if (gross_c) state_nxt = evt_c ? ST_C1 : ST_MEAS;
                else         state_nxt = ST_C2;
            end
            ST_C2:   state_nxt = ST_C3;
            ST_C3:   state_nxt = evt_c ? ST_C1 : ST_MEAS;
            default: state_nxt = ST_ACQ;
        endcase
    end

    always_comb begin
        err_d    = err_q;
        p_d      = p_q;
        integ_d  = integ_q;
        lcnt_d   = lcnt_q;
        pend_d   = pend;
        duty_d   = PWM_Duty;
        ferr_d   = Freq_Err;
        dv_d     = 1'b0;
        locked_d = Locked;
        hold_d   = Holdover;
        case (state)
            ST_ACQ, ST_HOLD: begin
                if (pps_rise) hold_d = 1'b0;
            end
            ST_MEAS: begin
                if (!pps_rise && timeout_c) begin
                    hold_d   = 1'b1;
                    locked_d = 1'b0;
                    lcnt_d   = '0;
                end
            end
            ST_C1: begin
                if (gross_c) begin
                    lcnt_d   = '0;
                    locked_d = 1'b0;
                    pend_d   = 1'b0;
                end else begin
                    pend_d = evt_c;
                    if (diff_c > DW'(ERR_LIM))       err_d = 16'(ERR_LIM);
                    else if (diff_c < -DW'(ERR_LIM)) err_d = -16'(ERR_LIM);
                    else                             err_d = 16'(diff_c);
                end
            end
            ST_C2: begin
                pend_d = evt_c;
                p_d    = DW'(err_q) <<< KP_SH;
                if (isum_c > DW'(INT_LIM))       integ_d = DW'(INT_LIM);
                else if (isum_c < -DW'(INT_LIM)) integ_d = -DW'(INT_LIM);
                else                             integ_d = isum_c;
            end
            ST_C3: begin
                pend_d = 1'b0;
                if (raw_c > DW'(DUTY_MAX))      duty_d = 16'(DUTY_MAX);
                else if (raw_c < DW'(DUTY_MIN)) duty_d = 16'(DUTY_MIN);
                else                            duty_d = 16'(raw_c);
                ferr_d = err_q;
                dv_d   = 1'b1;
                if (!in_tol_c)                       lcnt_d = '0;
                else if (lcnt_q != LCW'(LOCK_CNT))   lcnt_d = lcnt_q + LCW'(1);
                locked_d = (lcnt_d == LCW'(LOCK_CNT));
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_SYS) begin
        if (CLK_RST) begin
            err_q      <= '0;
            p_q        <= '0;
            integ_q    <= '0;
            lcnt_q     <= '0;
            pend       <= 1'b0;
            PWM_Duty   <= 16'(DUTY_INIT);
            Duty_Valid <= 1'b0;
            Freq_Err   <= '0;
            Locked     <= 1'b0;
            Holdover   <= 1'b0;
        end else begin
            err_q      <= err_d;
            p_q        <= p_d;
            integ_q    <= integ_d;
            lcnt_q     <= lcnt_d;
            pend       <= pend_d;
            PWM_Duty   <= duty_d;
            Duty_Valid <= dv_d;
            Freq_Err   <= ferr_d;
            Locked     <= locked_d;
            Holdover   <= hold_d;
        end
    end

endmodule

// File: tb/tb_pps_duty_ctrl.sv
// Bench for pps_duty_ctrl: two instances (normal and raised DUTY_MIN) against an
// edge-level loop model with directed and randomized PPS periods.
module tb_pps_duty_ctrl;

    localparam int NOMINAL   = 1000;
    localparam int GROSS_LIM = 100;
    localparam int ERR_LIM   = 50;
    localparam int KP_SH     = 4;
    localparam int KI_SH     = 2;
    localparam int INT_LIM   = 4096;
    localparam int DUTY_INIT = 32768;
    localparam int DMIN_A    = 1024;
    localparam int DMIN_B    = 30000;
    localparam int DUTY_MAX  = 64511;
    localparam int TIMEOUT   = 1500;
    localparam int LOCK_TOL  = 1;
    localparam int LOCK_CNT  = 3;
    localparam int M_ACQ = 0, M_MEAS = 1, M_HOLD = 2;

    logic        CLK_SYS = 1'b0;
    logic        CLK_RST;
    logic        PPS_In;
    logic [15:0] duty_a, ferr_a, duty_b, ferr_b;
    logic        dv_a, lk_a, ho_a, dv_b, lk_b, ho_b;

    always #5 CLK_SYS = ~CLK_SYS;

    pps_duty_ctrl #(
        .NOMINAL(NOMINAL), .GROSS_LIM(GROSS_LIM), .ERR_LIM(ERR_LIM), .KP_SH(KP_SH),
        .KI_SH(KI_SH), .INT_LIM(INT_LIM), .DUTY_INIT(DUTY_INIT), .DUTY_MIN(DMIN_A),
        .DUTY_MAX(DUTY_MAX), .TIMEOUT(TIMEOUT), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) u_dut_a (
        .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST), .PPS_In(PPS_In), .PWM_Duty(duty_a),
        .Duty_Valid(dv_a), .Freq_Err(ferr_a), .Locked(lk_a), .Holdover(ho_a)
    );

    pps_duty_ctrl #(
        .NOMINAL(NOMINAL), .GROSS_LIM(GROSS_LIM), .ERR_LIM(ERR_LIM), .KP_SH(KP_SH),
        .KI_SH(KI_SH), .INT_LIM(INT_LIM), .DUTY_INIT(DUTY_INIT), .DUTY_MIN(DMIN_B),
        .DUTY_MAX(DUTY_MAX), .TIMEOUT(TIMEOUT), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
    ) u_dut_b (
        .CLK_SYS(CLK_SYS), .CLK_RST(CLK_RST), .PPS_In(PPS_In), .PWM_Duty(duty_b),
        .Duty_Valid(dv_b), .Freq_Err(ferr_b), .Locked(lk_b), .Holdover(ho_b)
    );

    int   n_vec, n_err, cyc;
    logic pps_prev;
    int   rise_at, last_e, upd_at, mode;
    int   m_integ, m_lc, m_ferr;
    bit   m_locked, m_hold, m_dv;
    int   m_duty [2];
    int   pend_duty [2];
    int   pend_ferr;
    bit   pend_locked;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Loop law applied per measured second; results appear 3 edges after the sampled rise.
    task automatic pps_event();
        int period, d, err, p, raw;
        if (mode != M_MEAS) begin
            mode   = M_MEAS;
            m_hold = 1'b0;
        end else begin
            period = cyc - last_e;
            d      = period - NOMINAL;
            if (d > GROSS_LIM || d < -GROSS_LIM) begin
                m_locked = 1'b0;
                m_lc     = 0;
            end else begin
                err          = clampi(d, -ERR_LIM, ERR_LIM);
                p            = err * (1 << KP_SH);
                m_integ      = clampi(m_integ + err * (1 << KI_SH), -INT_LIM, INT_LIM);
                raw          = DUTY_INIT - (p + m_integ);
                pend_duty[0] = clampi(raw, DMIN_A, DUTY_MAX);
                pend_duty[1] = clampi(raw, DMIN_B, DUTY_MAX);
                pend_ferr    = err;
                m_lc         = (err <= LOCK_TOL && err >= -LOCK_TOL) ?
                               ((m_lc < LOCK_CNT) ? m_lc + 1 : LOCK_CNT) : 0;
                pend_locked  = (m_lc == LOCK_CNT);
                upd_at       = cyc + 3;
            end
        end
        last_e = cyc;
    endtask

    task automatic model_edge(input logic pps, input logic rst);
        cyc++;
        if (pps && !pps_prev) rise_at = cyc + 2;
        pps_prev = pps;
        m_dv = 1'b0;
        if (rst) begin
            mode      = M_ACQ;
            m_integ   = 0;
            m_lc      = 0;
            m_ferr    = 0;
            m_locked  = 1'b0;
            m_hold    = 1'b0;
            m_duty[0] = DUTY_INIT;
            m_duty[1] = DUTY_INIT;
            upd_at    = -1;
        end else begin
            if (upd_at == cyc) begin
                m_duty[0] = pend_duty[0];
                m_duty[1] = pend_duty[1];
                m_ferr    = pend_ferr;
                m_locked  = pend_locked;
                m_dv      = 1'b1;
                upd_at    = -1;
            end
            if (rise_at == cyc) begin
                pps_event();
            end else if (mode == M_MEAS && cyc == last_e + TIMEOUT) begin
                mode     = M_HOLD;
                m_hold   = 1'b1;
                m_locked = 1'b0;
                m_lc     = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("dv_a", 32'(dv_a), 32'(m_dv));
        check_val("dv_b", 32'(dv_b), 32'(m_dv));
        if (!(cyc >= last_e && cyc < last_e + 3) && (m_dv || (cyc % 16) == 0)) begin
            check_val("duty_a", 32'(duty_a), m_duty[0]);
            check_val("duty_b", 32'(duty_b), m_duty[1]);
            check_val("ferr_a", 32'(ferr_a), m_ferr & 32'hFFFF);
            check_val("ferr_b", 32'(ferr_b), m_ferr & 32'hFFFF);
            check_val("locked_a", 32'(lk_a), 32'(m_locked));
            check_val("locked_b", 32'(lk_b), 32'(m_locked));
            check_val("hold_a", 32'(ho_a), 32'(m_hold));
            check_val("hold_b", 32'(ho_b), 32'(m_hold));
        end
    endtask

    task automatic step(input logic pps, input logic rst);
        PPS_In  = pps;
        CLK_RST = rst;
        @(posedge CLK_SYS);
        #1;
        model_edge(pps, rst);
        compare_outputs();
    endtask

    // Rising edge lands exactly 'period' cycles after the previous call's edge.
    task automatic pulse(input int period);
        for (int i = 0; i < period; i++) step(i >= period - 10, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; pps_prev = 1'b0;
        rise_at = -1; last_e = -100; upd_at = -1; mode = M_ACQ;
        m_integ = 0; m_lc = 0; m_ferr = 0; m_locked = 1'b0; m_hold = 1'b0; m_dv = 1'b0;
        m_duty[0] = DUTY_INIT; m_duty[1] = DUTY_INIT;
        pend_duty[0] = 0; pend_duty[1] = 0; pend_ferr = 0; pend_locked = 1'b0;
        PPS_In = 1'b0; CLK_RST = 1'b1;

        repeat (3) step(1'b0, 1'b1);
        check_val("rst_duty", 32'(duty_a), 32768);
        check_val("rst_ferr", 32'(ferr_a), 0);
        check_val("rst_locked", 32'(lk_a), 0);
        check_val("rst_hold", 32'(ho_a), 0);
        repeat (5) step(1'b0, 1'b0);

        // Nominal periods: lock after the third update
        pulse(200);
        for (int k = 1; k <= 4; k++) begin
            pulse(1000);
            check_val("nom_duty", 32'(duty_a), 32768);
            check_val("nom_locked", 32'(lk_a), 32'(k >= 3));
        end

        // Small positive error
        pulse(1010);
        check_val("e10_ferr", 32'(ferr_a), 10);
        check_val("e10_duty1", 32'(duty_a), 32568);
        check_val("e10_unlock", 32'(lk_a), 0);
        pulse(1010);
        check_val("e10_duty2", 32'(duty_a), 32528);

        // Error clamp, then gross discard
        pulse(1080);
        check_val("clamp_ferr", 32'(ferr_a), 50);
        check_val("clamp_duty", 32'(duty_a), 31688);
        pulse(1200);
        check_val("gross_duty", 32'(duty_a), 31688);
        check_val("gross_locked", 32'(lk_a), 0);

        // Integrator and duty saturation
        repeat (25) pulse(1080);
        check_val("sat_duty_a", 32'(duty_a), 27872);
        check_val("sat_duty_b", 32'(duty_b), 30000);

        // PPS loss and recovery
        repeat (1600) step(1'b0, 1'b0);
        check_val("hold_set", 32'(ho_a), 1);
        check_val("hold_duty", 32'(duty_a), 27872);
        pulse(300);
        check_val("hold_clr", 32'(ho_a), 0);
        check_val("hold_nochg", 32'(duty_a), 27872);
        pulse(1000);
        check_val("resume_a", 32'(duty_a), 28672);
        check_val("resume_b", 32'(duty_b), 30000);

        // Reset inside the calculation window
        begin
            int r;
            r = int'($urandom_range(3, 5));
            repeat (990) step(1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b1, 1'(i == r));
        end
        check_val("abort_duty", 32'(duty_a), 32768);
        check_val("abort_ferr", 32'(ferr_a), 0);
        pulse(500);
        pulse(1010);
        check_val("abort_integ", 32'(duty_a), 32568);

        // Randomized periods: in-band, clamped, discarded and lost seconds
        for (int k = 0; k < 15; k++) begin
            int sel, per;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       per = int'($urandom_range(995, 1005));
            else if (sel < 8)  per = int'($urandom_range(1040, 1100));
            else if (sel < 9)  per = int'($urandom_range(1101, 1300));
            else               per = int'($urandom_range(1550, 1800));
            pulse(per);
        end
        repeat (20) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
